sap_controller: RTL and testbench
=================================

# sap_controller

Control sequencer for the SAP-1 datapath: a six-phase T-state ring counter plus instruction decoder that drives every load/enable line of the machine, including the five W-bus source enables consumed by the bus multiplexer. Sits upstream of the bus, PC, MAR, IR, accumulator, B register, ALU and output register; its only datapath input is the opcode nibble from the instruction register.

## Interface
Parameters:
- none (all encodings fixed in `sap_pkg`)

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  4  IR upper nibble; valid from T4 onward
- `pc_inc`  out  1  Cp, PC increment, active-high
- `pc_to_bus`  out  1  Ep, active-high
- `mar_load_n`  out  1  Lm, active-low
- `ram_to_bus`  out  1  Ce, active-low
- `ir_load_n`  out  1  Li, active-low
- `ir_to_bus`  out  1  Ei, active-low
- `acc_load_n`  out  1  La, active-low
- `a_to_bus`  out  1  Ea, active-high
- `ula_sub`  out  1  Su, 1 = subtract
- `ula_to_bus`  out  1  Eu, active-high
- `b_load_n`  out  1  Lb, active-low
- `out_load_n`  out  1  Lo, active-low
- `halt`  out  1  machine halted, active-high
- `t_state`  out  6  one-hot current phase, bit0 = T1; 0 in HALT

## Operation
- States: T1..T6, HALT. Advance Tn -> Tn+1 every clock; T6 -> T1.
- Fetch (all opcodes): T1 `pc_to_bus`, `mar_load_n`=0; T2 `pc_inc`; T3 `ram_to_bus`=0, `ir_load_n`=0.
- LDA 0000: T4 `ir_to_bus`=0, `mar_load_n`=0; T5 `ram_to_bus`=0, `acc_load_n`=0; T6 none.
- ADD 0001: T4 as LDA; T5 `ram_to_bus`=0, `b_load_n`=0; T6 `ula_to_bus`, `acc_load_n`=0.
- SUB 0010: as ADD, `ula_sub`=1 in T5 and T6.
- OUT 1110: T4 `a_to_bus`, `out_load_n`=0; T5, T6 none.
- HLT 1111: T4 no controls; T4 -> HALT. HALT: all controls inactive, `halt`=1; exits only on reset.
- Undefined opcodes: no controls in T4–T6 (NOP).
- At most one bus source enabled in any state.
- Inactive levels: active-high lines 0, active-low lines 1.

## Timing
- State register only; outputs are combinational decode of state and `opcode`.
- `reset` high: all controls forced inactive in the same cycle, `halt`=0, `t_state`=0; state <= T1 at the edge. First cycle after release is T1.
- Reset mid-instruction or in HALT: same; no partial instruction completes.
- Fixed instruction length 6 cycles (without config macro). `opcode` changes during T1–T3 are ignored.

## Configuration
- `SAP_VARIABLE_CYCLE_EN`: defined -> early return to T1 after the last active phase: LDA T5 -> T1 (5 cycles), OUT and undefined opcodes T4 -> T1 (4 cycles); ADD/SUB 6 cycles; HLT unchanged.
- Not defined -> every instruction runs T1..T6; NOP phases idle.

## Structure
- `sap_pkg`: opcode constants (`OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`), state enum (T1..T6, HALT), packed control-word struct with an `CTRL_IDLE` constant holding inactive levels.
- Sub-module `sap_ring_counter`: state register with inputs `clock`, `reset`, `restart` (early T1), `stop` (enter HALT); outputs state and `t_state`. Decoder lives in `sap_controller`.

## Test plan
- Reset 3 cycles then release, opcode=0000 -> cycle 1: `t_state`=000001, `pc_to_bus`=1, `mar_load_n`=0; during reset all controls idle.
- ADD (0001) full cycle -> T5 `ram_to_bus`=0, `b_load_n`=0; T6 `ula_to_bus`=1, `acc_load_n`=0, `ula_sub`=0; next cycle `t_state`=000001.
- SUB (0010) -> identical to ADD with `ula_sub`=1 in T5, T6 only.
- HLT (1111) -> T4 idle, then `halt`=1, `t_state`=0, held 20 cycles; reset -> T1.
- With `SAP_VARIABLE_CYCLE_EN`: LDA then OUT -> T1 reached after 5 and 4 cycles; without macro 6 each.
- Reset asserted in T5 of ADD -> `acc_load_n`/`b_load_n` never low afterward; resumes at T1.

Source files
------------

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - SAP-1 controller opcodes, phase states and control-word type
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    ST_T1   = 3'd0,
    ST_T2   = 3'd1,
    ST_T3   = 3'd2,
    ST_T4   = 3'd3,
    ST_T5   = 3'd4,
    ST_T6   = 3'd5,
    ST_HALT = 3'd6
  } sap_state_t;

  typedef struct packed {
    logic pc_inc;
    logic pc_to_bus;
    logic mar_load_n;
    logic ram_to_bus;
    logic ir_load_n;
    logic ir_to_bus;
    logic acc_load_n;
    logic a_to_bus;
    logic ula_sub;
    logic ula_to_bus;
    logic b_load_n;
    logic out_load_n;
    logic halt;
  } sap_ctrl_t;

  // Every line at its inactive level: active-high 0, active-low 1.
  localparam sap_ctrl_t CTRL_IDLE = '{
    pc_inc:     1'b0,
    pc_to_bus:  1'b0,
    mar_load_n: 1'b1,
    ram_to_bus: 1'b1,
    ir_load_n:  1'b1,
    ir_to_bus:  1'b1,
    acc_load_n: 1'b1,
    a_to_bus:   1'b0,
    ula_sub:    1'b0,
    ula_to_bus: 1'b0,
    b_load_n:   1'b1,
    out_load_n: 1'b1,
    halt:       1'b0
  };

  function automatic logic [5:0] state_onehot(input sap_state_t s);
    logic [5:0] v;
    v = 6'b000000;
    case (s)
      ST_T1:   v = 6'b000001;
      ST_T2:   v = 6'b000010;
      ST_T3:   v = 6'b000100;
      ST_T4:   v = 6'b001000;
      ST_T5:   v = 6'b010000;
      ST_T6:   v = 6'b100000;
      default: v = 6'b000000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// rtl/sap_ring_counter.sv - six-phase T-state ring counter with HALT state
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       restart,
  input  logic       stop,
  output sap_state_t state,
  output logic [5:0] t_state
);

  sap_state_t next_state;

  always_comb begin
    next_state = state;
    case (state)
      ST_T1:   next_state = ST_T2;
      ST_T2:   next_state = ST_T3;
      ST_T3:   next_state = ST_T4;
      ST_T4:   next_state = ST_T5;
      ST_T5:   next_state = ST_T6;
      ST_T6:   next_state = ST_T1;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_T1;
    endcase
    // HALT is sticky; only reset leaves it.
    if (state != ST_HALT) begin
      if (stop) begin
        next_state = ST_HALT;
      end else if (restart) begin
        next_state = ST_T1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_T1;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    t_state = reset ? 6'b000000 : state_onehot(state);
  end

endmodule

// File: rtl/sap_controller.sv
// rtl/sap_controller.sv - SAP-1 control sequencer; SAP_VARIABLE_CYCLE_EN enables early return to T1
module sap_controller
  import sap_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_to_bus,
  output logic       mar_load_n,
  output logic       ram_to_bus,
  output logic       ir_load_n,
  output logic       ir_to_bus,
  output logic       acc_load_n,
  output logic       a_to_bus,
  output logic       ula_sub,
  output logic       ula_to_bus,
  output logic       b_load_n,
  output logic       out_load_n,
  output logic       halt,
  output logic [5:0] t_state
);

`ifdef SAP_VARIABLE_CYCLE_EN
  localparam logic VAR_CYCLE = 1'b1;
`else
  localparam logic VAR_CYCLE = 1'b0;
`endif

  sap_state_t state;
  sap_ctrl_t  ctrl;
  logic       restart;
  logic       stop;

  sap_ring_counter u_ring (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .stop    (stop),
    .state   (state),
    .t_state (t_state)
  );

  always_comb begin
    ctrl    = CTRL_IDLE;
    restart = 1'b0;
    stop    = 1'b0;
    case (state)
      ST_T1: begin
        ctrl.pc_to_bus  = 1'b1;
        ctrl.mar_load_n = 1'b0;
      end
      ST_T2: ctrl.pc_inc = 1'b1;
      ST_T3: begin
        ctrl.ram_to_bus = 1'b0;
        ctrl.ir_load_n  = 1'b0;
      end
      ST_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl.ir_to_bus  = 1'b0;
            ctrl.mar_load_n = 1'b0;
          end
          OP_OUT: begin
            ctrl.a_to_bus   = 1'b1;
            ctrl.out_load_n = 1'b0;
            restart         = VAR_CYCLE;
          end
          OP_HLT:  stop    = 1'b1;
          default: restart = VAR_CYCLE;
        endcase
      end
      ST_T5: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_to_bus = 1'b0;
            ctrl.acc_load_n = 1'b0;
            restart         = VAR_CYCLE;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_to_bus = 1'b0;
            ctrl.b_load_n   = 1'b0;
            ctrl.ula_sub    = (opcode == OP_SUB);
          end
          default: ;
        endcase
      end
      ST_T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl.ula_to_bus = 1'b1;
          ctrl.acc_load_n = 1'b0;
          ctrl.ula_sub    = (opcode == OP_SUB);
        end
      end
      ST_HALT: ctrl.halt = 1'b1;
      default: ;
    endcase
    // Reset masks the decode in the same cycle so no partial instruction leaks out.
    if (reset) begin
      ctrl = CTRL_IDLE;
    end
  end

  assign pc_inc     = ctrl.pc_inc;
  assign pc_to_bus  = ctrl.pc_to_bus;
  assign mar_load_n = ctrl.mar_load_n;
  assign ram_to_bus = ctrl.ram_to_bus;
  assign ir_load_n  = ctrl.ir_load_n;
  assign ir_to_bus  = ctrl.ir_to_bus;
  assign acc_load_n = ctrl.acc_load_n;
  assign a_to_bus   = ctrl.a_to_bus;
  assign ula_sub    = ctrl.ula_sub;
  assign ula_to_bus = ctrl.ula_to_bus;
  assign b_load_n   = ctrl.b_load_n;
  assign out_load_n = ctrl.out_load_n;
  assign halt       = ctrl.halt;

endmodule

// File: tb/tb_sap_controller.sv
// tb/tb_sap_controller.sv - directed self-checking bench for sap_controller
module tb_sap_controller;

  logic       clock;
  logic       reset;
  logic [3:0] opcode;
  logic       pc_inc, pc_to_bus, mar_load_n, ram_to_bus, ir_load_n, ir_to_bus;
  logic       acc_load_n, a_to_bus, ula_sub, ula_to_bus, b_load_n, out_load_n, halt;
  logic [5:0] t_state;
  logic [12:0] ctl;

  int total = 0;
  int bad   = 0;

  // Bit order: pc_inc pc_to_bus mar_load_n ram_to_bus ir_load_n ir_to_bus
  //            acc_load_n a_to_bus ula_sub ula_to_bus b_load_n out_load_n halt
  localparam logic [12:0] W_IDLE   = 13'b0011111000110;
  localparam logic [12:0] W_T1     = 13'b0101111000110;
  localparam logic [12:0] W_T2     = 13'b1011111000110;
  localparam logic [12:0] W_T3     = 13'b0010011000110;
  localparam logic [12:0] W_T4_MEM = 13'b0001101000110;
  localparam logic [12:0] W_LDA_T5 = 13'b0010110000110;
  localparam logic [12:0] W_ADD_T5 = 13'b0010111000010;
  localparam logic [12:0] W_ADD_T6 = 13'b0011110001110;
  localparam logic [12:0] W_SUB_T5 = 13'b0010111010010;
  localparam logic [12:0] W_SUB_T6 = 13'b0011110011110;
  localparam logic [12:0] W_OUT_T4 = 13'b0011111100100;
  localparam logic [12:0] W_HALT   = 13'b0011111000111;

`ifdef SAP_VARIABLE_CYCLE_EN
  localparam int LDA_LEN = 5;
  localparam int NOP_LEN = 4;
`else
  localparam int LDA_LEN = 6;
  localparam int NOP_LEN = 6;
`endif

  sap_controller dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .pc_inc     (pc_inc),
    .pc_to_bus  (pc_to_bus),
    .mar_load_n (mar_load_n),
    .ram_to_bus (ram_to_bus),
    .ir_load_n  (ir_load_n),
    .ir_to_bus  (ir_to_bus),
    .acc_load_n (acc_load_n),
    .a_to_bus   (a_to_bus),
    .ula_sub    (ula_sub),
    .ula_to_bus (ula_to_bus),
    .b_load_n   (b_load_n),
    .out_load_n (out_load_n),
    .halt       (halt),
    .t_state    (t_state)
  );

  assign ctl = {pc_inc, pc_to_bus, mar_load_n, ram_to_bus, ir_load_n, ir_to_bus,
                acc_load_n, a_to_bus, ula_sub, ula_to_bus, b_load_n, out_load_n, halt};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_phase(input string tag, input logic [12:0] exp_ctl, input logic [5:0] exp_t);
    chk({tag, "_ctl"}, {3'b000, ctl}, {3'b000, exp_ctl});
    chk({tag, "_t"}, {10'd0, t_state}, {10'd0, exp_t});
  endtask

  // Fetch runs with a junk opcode to show T1-T3 ignore it.
  task automatic do_instr(input string name, input logic [3:0] op, input logic [12:0] e4,
                          input logic [12:0] e5, input logic [12:0] e6, input int len);
    opcode = 4'b1111;
    chk_phase({name, "_t1"}, W_T1, 6'b000001);
    tick();
    chk_phase({name, "_t2"}, W_T2, 6'b000010);
    tick();
    chk_phase({name, "_t3"}, W_T3, 6'b000100);
    opcode = op;
    tick();
    chk_phase({name, "_t4"}, e4, 6'b001000);
    if (len > 4) begin
      tick();
      chk_phase({name, "_t5"}, e5, 6'b010000);
    end
    if (len > 5) begin
      tick();
      chk_phase({name, "_t6"}, e6, 6'b100000);
    end
    tick();
    chk({name, "_wrap"}, {10'd0, t_state}, 16'h0001);
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_phase("in_reset", W_IDLE, 6'b000000);
    end
    reset = 1'b0;
    #1;
    chk_phase("first_t1", W_T1, 6'b000001);

    do_instr("lda", 4'b0000, W_T4_MEM, W_LDA_T5, W_IDLE, LDA_LEN);
    do_instr("add", 4'b0001, W_T4_MEM, W_ADD_T5, W_ADD_T6, 6);
    do_instr("sub", 4'b0010, W_T4_MEM, W_SUB_T5, W_SUB_T6, 6);
    do_instr("out", 4'b1110, W_OUT_T4, W_IDLE, W_IDLE, NOP_LEN);
    do_instr("nop", 4'b0101, W_IDLE, W_IDLE, W_IDLE, NOP_LEN);

    // Abort an ADD in T5; the accumulator write of T6 must never appear.
    opcode = 4'b0001;
    tick(); tick(); tick(); tick();
    chk_phase("abort_t5", W_ADD_T5, 6'b010000);
    reset = 1'b1;
    #1;
    chk_phase("abort_rst", W_IDLE, 6'b000000);
    tick();
    reset = 1'b0;
    #1;
    do_instr("out_after_abort", 4'b1110, W_OUT_T4, W_IDLE, W_IDLE, NOP_LEN);

    opcode = 4'b1111;
    chk_phase("hlt_t1", W_T1, 6'b000001);
    tick();
    chk_phase("hlt_t2", W_T2, 6'b000010);
    tick();
    chk_phase("hlt_t3", W_T3, 6'b000100);
    tick();
    chk_phase("hlt_t4", W_IDLE, 6'b001000);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk_phase("halted", W_HALT, 6'b000000);
      opcode = 4'(i);
      tick();
    end
    reset = 1'b1;
    #1;
    chk_phase("halt_rst", W_IDLE, 6'b000000);
    tick();
    reset  = 1'b0;
    opcode = 4'b0000;
    #1;
    chk_phase("halt_exit_t1", W_T1, 6'b000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
